simon_autoplayer: RTL and testbench
===================================

# simon_autoplayer

Autonomous player for the Simon game: it sits on the far side of Simon's button/LED interface and drives `pattern` and the `pclk` press strobe in place of a human. It watches `mode_leds`, steps through PLAYBACK while recording `pattern_leds` into a local sequence memory, and replays the recorded sequence during REPEAT. It is used for self-play regression against Simon and on-board demo mode.

## Interface
- `DEPTH`, 64: sequence memory entries; must match Simon's pattern memory.
- `PRESS_CYCLES`, 4: `sysclk` cycles `pclk` is held high per press (≥1).
- `SETTLE_CYCLES`, 4: `sysclk` cycles after `pclk` falls before LEDs are sampled (≥2).
- `sysclk`  in  1  system clock; all logic rising-edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  run player; low forces IDLE.
- `err_en`  in  1  inject one wrong entry during REPEAT.
- `err_idx`  in  6  repeat index to corrupt (pattern bits inverted).
- `mode_leds`  in  3  Simon mode: 001 INPUT, 010 PLAYBACK, 100 REPEAT, 111 DONE.
- `pattern_leds`  in  4  Simon pattern display.
- `pclk`  out  1  press strobe to Simon `pclk`.
- `pattern`  out  4  switch value to Simon `pattern`.
- `busy`  out  1  FSM not IDLE/FINISHED.
- `finished`  out  1  DONE observed.
- `overflow`  out  1  capture exceeded DEPTH.
- `cap_len`  out  7  entries captured this round (0..DEPTH).
- `rounds`  out  8  completed REPEAT phases, saturating at 255.

## Operation
- States: IDLE, WATCH, CAP_PRESS, CAP_SETTLE, REP_DRIVE, REP_PRESS, REP_SETTLE, FINISHED.
- IDLE: `pclk`=0, `pattern`=0. `enable`=1 -> WATCH.
- WATCH decodes `mode_leds`: INPUT -> stay (passive); PLAYBACK -> clear `wr_ptr`, CAP_PRESS; REPEAT -> `rd_ptr`=0, REP_DRIVE; DONE -> FINISHED; any other code -> stay.
- CAP_PRESS: `pclk` high PRESS_CYCLES, then low -> CAP_SETTLE.
- CAP_SETTLE: after SETTLE_CYCLES, if mode still PLAYBACK write `pattern_leds` to `mem[wr_ptr]`, increment `wr_ptr`, -> CAP_PRESS. If mode changed, do not write; -> WATCH.
- Capture when `wr_ptr`==DEPTH: set `overflow`, -> FINISHED.
- REP_DRIVE: `pattern` = `mem[rd_ptr]`, or its bitwise inverse if `err_en` and `rd_ptr`==`err_idx`; -> REP_PRESS one cycle later.
- REP_PRESS/REP_SETTLE: same timing as capture, with `pattern` held. After settle: mode REPEAT and `rd_ptr+1`<`cap_len` -> increment, REP_DRIVE. Mode REPEAT and all entries sent -> wait in REP_SETTLE without pressing. Mode PLAYBACK -> `rounds++`, WATCH (new round re-captures from 0). Mode DONE -> FINISHED.
- FINISHED: `finished`=1, no presses. Leaves only via `enable`=0 -> IDLE.
- `enable` falling in any state: `pclk` drops the next cycle; -> IDLE; pointers, `cap_len`, and flags clear.
- `cap_len` mirrors `wr_ptr`; 7-bit to represent DEPTH.

## Timing
- Reset (async, `rst`=0): all outputs 0, state IDLE, pointers 0. Memory contents undefined, never read before written.
- All outputs registered. `pattern` is stable ≥1 cycle before `pclk` rises and held until the next REP_DRIVE.
- Press period = PRESS_CYCLES + SETTLE_CYCLES (+1 for REP_DRIVE in repeat).
- `mode_leds`/`pattern_leds` are sampled only at the end of a settle window or in WATCH. Both are treated as quasi-static. No synchronizer is used because Simon is clocked by this block's `pclk`.
- Simultaneous `enable`=0 and a mode change: `enable` wins.

## Structure
- Shared package `simon_pkg`: mode LED codes (`LED_MODE_INPUT/PLAYBACK/REPEAT/DONE`), FSM state encoding, pattern width 4.
- Sub-module `simon_seq_mem`: DEPTH×4 single-port synchronous-write / async-read memory. The FSM, press timer, and pointers remain in the top module.

## Test plan
- Reset mid-press (`rst`=0 while `pclk`=1) -> `pclk`, `pattern`, `busy`, `cap_len` all 0 immediately.
- Behavioural Simon model plays 3 entries {4'h1,4'h2,4'h8} in PLAYBACK -> `cap_len`=3; REPEAT receives 1,2,8 in order; `rounds`=1.
- Full game with real `Simon`, 5 rounds, `err_en`=0 -> `rounds`=5, no DONE, `pclk` high exactly PRESS_CYCLES per press.
- `err_en`=1, `err_idx`=1, sequence {4'h3,4'h5} -> second repeat entry 4'hA; Simon shows DONE (111); `finished`=1 within one settle window.
- Model keeps PLAYBACK for 65 presses -> `overflow`=1 after entry 64, `cap_len`=64, FINISHED.
- `enable` dropped during REP_PRESS -> `pclk` 0 next cycle, IDLE, `rounds`=0.

Source files
------------

// File: rtl/simon_pkg.sv
// simon_pkg: mode LED codes, FSM state encoding and pattern width shared by the Simon autoplayer.
package simon_pkg;
  localparam int PAT_W = 4;
  localparam logic [2:0] LED_MODE_INPUT    = 3'b001;
  localparam logic [2:0] LED_MODE_PLAYBACK = 3'b010;
  localparam logic [2:0] LED_MODE_REPEAT   = 3'b100;
  localparam logic [2:0] LED_MODE_DONE     = 3'b111;
  typedef enum logic [2:0] {
    IDLE, WATCH, CAP_PRESS, CAP_SETTLE, REP_DRIVE, REP_PRESS, REP_SETTLE, FINISHED
  } state_t;
  function automatic logic is_busy(state_t s);
    return (s != IDLE) && (s != FINISHED);
  endfunction
endpackage

// File: rtl/simon_seq_mem.sv
// simon_seq_mem: single-port sequence store, synchronous write and asynchronous read.
module simon_seq_mem
  import simon_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [PAT_W-1:0]         wdata,
  output logic [PAT_W-1:0]         rdata
);
  logic [PAT_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/simon_autoplayer.sv
// simon_autoplayer: presses Simon's buttons in place of a player, recording the
// PLAYBACK sequence and replaying it during REPEAT.
module simon_autoplayer
  import simon_pkg::*;
#(
  parameter int DEPTH         = 64,
  parameter int PRESS_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                     sysclk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     err_en,
  input  logic [$clog2(DEPTH)-1:0] err_idx,
  input  logic [2:0]               mode_leds,
  input  logic [PAT_W-1:0]         pattern_leds,
  output logic                     pclk,
  output logic [PAT_W-1:0]         pattern,
  output logic                     busy,
  output logic                     finished,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   cap_len,
  output logic [7:0]               rounds
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0] PRESS_LAST  = 8'(PRESS_CYCLES - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  state_t state_q, state_d;
  logic [7:0] timer_q, timer_d, rounds_q, rounds_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
  logic pclk_q, pclk_d, busy_q, busy_d, finished_q, finished_d, overflow_q, overflow_d;
  logic [PAT_W-1:0] pattern_q, pattern_d, mem_rdata, rep_pat;
  logic [AW-1:0] mem_addr;
  logic settle_done, we;
  assign settle_done = timer_q == SETTLE_LAST;
  // Replay entry about to be driven: index 0 when leaving WATCH, otherwise the next one.
  assign rd_next = (state_q == WATCH) ? '0 : rd_ptr_q + 1'b1;
  assign we = enable && state_q == CAP_SETTLE && settle_done &&
              mode_leds == LED_MODE_PLAYBACK && wr_ptr_q != FULL;
  assign mem_addr = we ? wr_ptr_q[AW-1:0] : rd_next[AW-1:0];
  assign rep_pat = mem_rdata ^ {PAT_W{err_en && rd_next == {1'b0, err_idx}}};
  simon_seq_mem #(.DEPTH(DEPTH)) u_mem (
    .clk  (sysclk),
    .we   (we),
    .addr (mem_addr),
    .wdata(pattern_leds),
    .rdata(mem_rdata)
  );
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q + 8'd1;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pclk_d     = pclk_q;
    pattern_d  = pattern_q;
    overflow_d = overflow_q;
    rounds_d   = rounds_q;
    if (!enable) begin
      state_d    = IDLE;
      timer_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      pclk_d     = 1'b0;
      pattern_d  = '0;
      overflow_d = 1'b0;
      rounds_d   = '0;
    end else begin
      case (state_q)
        IDLE: state_d = WATCH;
        WATCH: begin
          timer_d = '0;
          if (mode_leds == LED_MODE_PLAYBACK) begin
            wr_ptr_d = '0;
            pclk_d   = 1'b1;
            state_d  = CAP_PRESS;
          end else if (mode_leds == LED_MODE_REPEAT) begin
            rd_ptr_d  = '0;
            pattern_d = (wr_ptr_q == '0) ? pattern_q : rep_pat;
            state_d   = (wr_ptr_q == '0) ? REP_SETTLE : REP_DRIVE;
          end else if (mode_leds == LED_MODE_DONE) begin
            state_d = FINISHED;
          end
        end
        CAP_PRESS, REP_PRESS: if (timer_q == PRESS_LAST) begin
          pclk_d  = 1'b0;
          timer_d = '0;
          state_d = (state_q == CAP_PRESS) ? CAP_SETTLE : REP_SETTLE;
        end
        CAP_SETTLE: if (settle_done) begin
          timer_d = '0;
          if (mode_leds != LED_MODE_PLAYBACK) begin
            state_d = WATCH;
          end else if (wr_ptr_q == FULL) begin
            overflow_d = 1'b1;
            state_d    = FINISHED;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            pclk_d   = 1'b1;
            state_d  = CAP_PRESS;
          end
        end
        REP_DRIVE: begin
          pclk_d  = 1'b1;
          timer_d = '0;
          state_d = REP_PRESS;
        end
        REP_SETTLE: if (settle_done) begin
          // Holding the timer at its last value keeps re-polling the mode while all entries are sent.
          if (mode_leds == LED_MODE_REPEAT) begin
            timer_d = SETTLE_LAST;
            if (rd_next < wr_ptr_q) begin
              rd_ptr_d  = rd_next;
              pattern_d = rep_pat;
              timer_d   = '0;
              state_d   = REP_DRIVE;
            end
          end else begin
            timer_d = '0;
            state_d = (mode_leds == LED_MODE_DONE) ? FINISHED : WATCH;
            if (mode_leds == LED_MODE_PLAYBACK) rounds_d = rounds_q + 8'(rounds_q != 8'hFF);
          end
        end
        default: timer_d = '0;
      endcase
    end
    busy_d     = is_busy(state_d);
    finished_d = state_d == FINISHED;
  end
  always_ff @(posedge sysclk or negedge rst)
    if (!rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pclk_q     <= 1'b0;
      pattern_q  <= '0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
      overflow_q <= 1'b0;
      rounds_q   <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pclk_q     <= pclk_d;
      pattern_q  <= pattern_d;
      busy_q     <= busy_d;
      finished_q <= finished_d;
      overflow_q <= overflow_d;
      rounds_q   <= rounds_d;
    end
  assign pclk     = pclk_q;
  assign pattern  = pattern_q;
  assign busy     = busy_q;
  assign finished = finished_q;
  assign overflow = overflow_q;
  assign cap_len  = wr_ptr_q;
  assign rounds   = rounds_q;
endmodule

// File: tb/tb_simon_autoplayer.sv
// tb_simon_autoplayer: a behavioural Simon answers the autoplayer's presses while a
// per-cycle checker compares every press against what Simon expects to see.
module tb_simon_autoplayer;
  import simon_pkg::*;
  localparam int PRESS_CYCLES  = 4;
  localparam int SETTLE_CYCLES = 4;
  logic sysclk = 1'b0, rst = 1'b1, enable = 1'b0, err_en = 1'b0;
  logic [5:0] err_idx = '0;
  logic [2:0] mode_leds = LED_MODE_INPUT;
  logic [3:0] pattern_leds = '0;
  logic pclk, busy, finished, overflow;
  logic [3:0] pattern;
  logic [6:0] cap_len;
  logic [7:0] rounds;
  int n_tests = 0, n_fail = 0;
  logic mon = 1'b0;
  logic [3:0] seq [128];
  int len = 0, pidx = 0, ridx = 0, rounds_done = 0;
  logic [3:0] rep_q [$];

  simon_autoplayer #(.DEPTH(64), .PRESS_CYCLES(PRESS_CYCLES), .SETTLE_CYCLES(SETTLE_CYCLES)) dut (
    .sysclk(sysclk), .rst(rst), .enable(enable), .err_en(err_en), .err_idx(err_idx),
    .mode_leds(mode_leds), .pattern_leds(pattern_leds), .pclk(pclk), .pattern(pattern),
    .busy(busy), .finished(finished), .overflow(overflow), .cap_len(cap_len), .rounds(rounds)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Simon: each PLAYBACK press shows the next entry, the press after the last one enters
  // REPEAT; REPEAT presses are judged, a wrong one ends the game, a full correct
  // sequence grows it by one entry and starts a new PLAYBACK.
  initial forever begin
    @(negedge pclk);
    if (mode_leds == LED_MODE_PLAYBACK) begin
      if (pidx < len) begin
        pattern_leds = seq[pidx];
        pidx++;
      end else begin
        mode_leds = LED_MODE_REPEAT;
        ridx = 0;
      end
    end else if (mode_leds == LED_MODE_REPEAT) begin
      rep_q.push_back(pattern);
      if (pattern != seq[ridx]) mode_leds = LED_MODE_DONE;
      else begin
        ridx++;
        if (ridx == len && len < 128) begin
          len++;
          rounds_done++;
          pidx = 0;
          mode_leds = LED_MODE_PLAYBACK;
        end
      end
    end
  end

  // Per-cycle checker: press width, settle gap, pattern stability and per-press expectations.
  initial begin
    int hi, lo;
    logic pp;
    logic [3:0] pat_prev;
    hi = 0; lo = SETTLE_CYCLES; pp = 1'b0; pat_prev = '0;
    forever begin
      @(negedge sysclk);
      if (!mon || !rst || !enable) begin
        hi = 0; lo = SETTLE_CYCLES;
      end else if (pclk) begin
        if (!pp) begin
          chk("settle_gap", 32'(lo >= SETTLE_CYCLES), 1);
          chk("press_after_done", 32'(mode_leds != LED_MODE_DONE), 1);
          chk("cap_len_at_press", 32'(cap_len), mode_leds == LED_MODE_REPEAT ? 32'(len) : 32'(pidx));
          chk("rounds_at_press", 32'(rounds), 32'(rounds_done));
          if (mode_leds == LED_MODE_REPEAT)
            chk("repeat_pattern", 32'(pattern), 32'(seq[ridx] ^ {4{err_en && ridx == int'(err_idx)}}));
        end
        chk("pattern_stable", 32'(pattern), 32'(pat_prev));
        chk("busy_in_press", 32'(busy), 1);
        hi++; lo = 0;
      end else begin
        if (pp) chk("press_width", 32'(hi), PRESS_CYCLES);
        hi = 0; lo++;
      end
      pp = pclk; pat_prev = pattern;
    end
  end

  task automatic start();
    mode_leds = LED_MODE_PLAYBACK;
    pattern_leds = '0;
    pidx = 0; ridx = 0; rounds_done = 0;
    rep_q.delete();
    @(negedge sysclk);
    mon = 1'b1;
    enable = 1'b1;
  endtask

  task automatic stop();
    mon = 1'b0;
    enable = 1'b0;
    err_en = 1'b0;
    repeat (3) @(negedge sysclk);
  endtask

  initial begin
    // Reset state
    #2 rst = 1'b0;
    #1;
    chk("rst_pclk", 32'(pclk), 0);
    chk("rst_pattern", 32'(pattern), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_finished", 32'(finished), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_cap_len", 32'(cap_len), 0);
    chk("rst_rounds", 32'(rounds), 0);
    @(negedge sysclk) rst = 1'b1;

    // Three-entry round {1,2,8}
    for (int i = 0; i < 128; i++) seq[i] = 4'(1 << (i % 4));
    seq[2] = 4'h8; seq[3] = 4'h4; len = 3;
    start();
    for (int i = 0; i < 1000 && rounds != 8'd1; i++) @(negedge sysclk);
    chk("a_rounds", 32'(rounds), 1);
    chk("a_cap_len", 32'(cap_len), 3);
    chk("a_rep_count", 32'(rep_q.size()), 3);
    chk("a_rep0", 32'(rep_q[0]), 32'h1);
    chk("a_rep1", 32'(rep_q[1]), 32'h2);
    chk("a_rep2", 32'(rep_q[2]), 32'h8);
    stop();

    // Reset in the middle of the first repeat press
    seq[2] = 4'h8; len = 3;
    start();
    for (int i = 0; i < 1000 && !(pclk && mode_leds == LED_MODE_REPEAT); i++) @(negedge sysclk);
    chk("mr_pre_pclk", 32'(pclk), 1);
    chk("mr_pre_pattern", 32'(pattern), 1);
    chk("mr_pre_cap_len", 32'(cap_len), 3);
    mon = 1'b0;
    rst = 1'b0;
    #1;
    chk("mr_pclk", 32'(pclk), 0);
    chk("mr_pattern", 32'(pattern), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_cap_len", 32'(cap_len), 0);
    enable = 1'b0;
    @(negedge sysclk) rst = 1'b1;
    stop();

    // Five clean rounds
    for (int i = 0; i < 128; i++) seq[i] = 4'(1 << (i % 4));
    len = 1;
    start();
    for (int i = 0; i < 4000 && rounds != 8'd5; i++) @(negedge sysclk);
    chk("game_rounds", 32'(rounds), 5);
    chk("game_not_done", 32'(mode_leds != LED_MODE_DONE), 1);
    chk("game_finished", 32'(finished), 0);
    chk("game_rep_count", 32'(rep_q.size()), 15);
    stop();

    // Injected error on the second repeat entry
    seq[0] = 4'h3; seq[1] = 4'h5; len = 2;
    err_idx = 6'd1;
    err_en = 1'b1;
    start();
    for (int i = 0; i < 1000 && mode_leds != LED_MODE_DONE; i++) @(negedge sysclk);
    chk("err_mode_done", 32'(mode_leds), 32'(LED_MODE_DONE));
    begin
      int cnt;
      cnt = 0;
      while (!finished && cnt < 20) begin
        @(negedge sysclk);
        cnt++;
      end
      chk("err_finish_latency", 32'(cnt <= SETTLE_CYCLES), 1);
    end
    chk("err_finished", 32'(finished), 1);
    chk("err_busy", 32'(busy), 0);
    chk("err_rep0", 32'(rep_q[0]), 32'h3);
    chk("err_rep1", 32'(rep_q[1]), 32'hA);
    chk("err_rounds", 32'(rounds), 0);
    stop();

    // PLAYBACK that never ends: 65th press overflows
    for (int i = 0; i < 128; i++) seq[i] = 4'(i);
    len = 70;
    start();
    for (int i = 0; i < 2000 && !finished; i++) @(negedge sysclk);
    chk("ovf_finished", 32'(finished), 1);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_cap_len", 32'(cap_len), 64);
    chk("ovf_presses", 32'(pidx), 65);
    chk("ovf_busy", 32'(busy), 0);
    repeat (SETTLE_CYCLES + PRESS_CYCLES + 2) @(negedge sysclk);
    chk("ovf_no_more_presses", 32'(pidx), 65);
    stop();

    // enable dropped during a repeat press
    seq[0] = 4'h3; seq[1] = 4'h5; len = 2;
    start();
    for (int i = 0; i < 1000 && !(pclk && mode_leds == LED_MODE_REPEAT); i++) @(negedge sysclk);
    chk("en_pre_pclk", 32'(pclk), 1);
    chk("en_pre_busy", 32'(busy), 1);
    mon = 1'b0;
    enable = 1'b0;
    @(negedge sysclk);
    chk("en_pclk", 32'(pclk), 0);
    chk("en_busy", 32'(busy), 0);
    chk("en_rounds", 32'(rounds), 0);
    chk("en_cap_len", 32'(cap_len), 0);
    chk("en_pattern", 32'(pattern), 0);
    stop();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
